via_adb_shifter: RTL and testbench
==================================

// Module: via_adb_shifter
// PURPOSE
//  Emulates the 6522 VIA shift-register (SR) path between the CPU and the ADB transceiver.
//  CPU byte writes are shifted out over 8 bit times, then handed to the transceiver as adb_din/adb_din_strobe.
//  Bytes from the transceiver (adb_dout/adb_dout_strobe) are shifted in over 8 bit times, then presented in SR.
//  Each completed byte raises the SR interrupt; viaBusy tells the transceiver a shift is in progress.
// PARAMETERS
//  BIT_TICKS  10  clk_en ticks per shifted bit; a byte takes 8*BIT_TICKS ticks (range 1..255)
// PORTS
//  clk             in   1  system clock
//  _reset          in   1  asynchronous, active-low reset
//  clk_en          in   1  clock enable; all state advances only when high
//  sr_dir          in   1  SR mode from VIA ACR: 1 = shift out (CPU->ADB), 0 = shift in (ADB->CPU)
//  sr_wr           in   1  CPU write strobe to SR (one clk_en cycle)
//  sr_rd           in   1  CPU read strobe of SR (one clk_en cycle)
//  cpu_din         in   8  CPU write data
//  sr_dout         out  8  current SR contents (CPU read data)
//  sr_irq          out  1  IFR bit 2, SR interrupt flag
//  viaBusy         out  1  high while a byte shift is in progress
//  adb_din         out  8  byte delivered to the transceiver
//  adb_din_strobe  out  1  one-clk_en-cycle pulse: adb_din valid
//  adb_dout        in   8  byte from the transceiver
//  adb_dout_strobe in   1  one-clk_en-cycle pulse: adb_dout valid
//  overrun         out  1  sticky: a transceiver byte was dropped; cleared by sr_rd
// BEHAVIOUR
//  Reset (_reset low, async): sr_dout=8'h00, adb_din=8'h00, sr_irq=0, viaBusy=0, adb_din_strobe=0, overrun=0,
//   state IDLE, pending empty, tick/bit counters 0.
//  States:
//   IDLE    -> SHOUT on sr_wr with sr_dir=1
//           -> SHIN  on adb_dout_strobe (or pending full) with sr_dir=0
//   SHOUT   -> IDLE  after 8*BIT_TICKS clk_en ticks
//   SHIN    -> IDLE  after 8*BIT_TICKS clk_en ticks
//  Counters: tick counter 0..BIT_TICKS-1; bit counter 0..7. The byte completes on the tick where bit=7 and tick=BIT_TICKS-1.
//  viaBusy=1 exactly while in SHOUT or SHIN; it asserts on the clk_en cycle after the start event.
//  SHOUT:
//   - sr_wr loads sr_dout=cpu_din and clears sr_irq.
//   - On completion: adb_din<=sr_dout, adb_din_strobe=1 for one clk_en cycle, sr_irq<=1, viaBusy<=0.
//   - Total latency sr_wr -> adb_din_strobe = 8*BIT_TICKS+1 clk_en cycles.
//  SHIN:
//   - The start byte is held internally; sr_dout is unchanged until completion.
//   - On completion: sr_dout<=held byte, sr_irq<=1.
//  Pending register (1 deep):
//   - adb_dout_strobe while SHIN, or while SHOUT, stores the byte in pending.
//   - If pending is already full, the new byte is dropped and overrun<=1.
//   - A full pending starts SHIN from IDLE on the next clk_en cycle when sr_dir=0.
//  sr_rd clears sr_irq and overrun. sr_wr clears sr_irq.
//  If an irq set and a clear land on the same cycle, the set wins.
//  sr_wr while sr_dir=0: loads sr_dout only; no shift starts.
//  sr_wr during SHOUT: reloads sr_dout and restarts the counters; no strobe for the aborted byte.
//  sr_dir changes while busy: abort the shift.
//   - Return to IDLE, viaBusy=0, no strobe, sr_irq unchanged. Pending is kept.
//  clk_en low freezes all state; strobes are only meaningful on clk_en cycles.
// TESTING
//  1. BIT_TICKS=2, sr_dir=1, sr_wr cpu_din=8'h3C -> viaBusy high 16 ticks; adb_din=8'h3C with one strobe; sr_irq=1.
//  2. sr_dir=0, adb_dout_strobe 8'hA5 -> 16 ticks later sr_dout=8'hA5, sr_irq=1.
//     Then sr_rd -> sr_irq=0.
//  3. sr_dir=0, bytes 8'h11, 8'h22, 8'h33 strobed 1 tick apart -> 8'h11 then 8'h22 appear in SR.
//     8'h33 is dropped and overrun=1; sr_rd clears overrun.
//  4. Shift out 8'h55, flip sr_dir at tick 5 -> no adb_din_strobe, viaBusy=0 next cycle, sr_irq stays 0.
//  5. Assert _reset mid-SHOUT -> all outputs at reset values immediately; no strobe after release.
//  6. sr_rd on the exact completion tick of a shift-in -> sr_irq=1 (set wins).

Source files
------------

// File: rtl/via_adb_shifter.sv
// ============================================================================
// Module   : via_adb_shifter
// Function : 6522 VIA shift-register path between the CPU and the ADB
//            transceiver, with a one-deep pending buffer for inbound bytes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module via_adb_shifter #(
    parameter int BIT_TICKS = 10
) (
    input  logic       clk,
    input  logic       _reset,
    input  logic       clk_en,
    input  logic       sr_dir,
    input  logic       sr_wr,
    input  logic       sr_rd,
    input  logic [7:0] cpu_din,
    output logic [7:0] sr_dout,
    output logic       sr_irq,
    output logic       viaBusy,
    output logic [7:0] adb_din,
    output logic       adb_din_strobe,
    input  logic [7:0] adb_dout,
    input  logic       adb_dout_strobe,
    output logic       overrun
);

    localparam logic [7:0] c_TICK_LAST = 8'(BIT_TICKS - 1);
    localparam logic [2:0] c_BIT_LAST  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHOUT = 2'd1,
        S_SHIN  = 2'd2
    } state_t;

    state_t     state_q,    state_d;
    logic [7:0] tick_q,     tick_d;
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic [7:0] hold_q,     hold_d;
    logic [7:0] pend_q,     pend_d;
    logic       pend_vld_q, pend_vld_d;
    logic [7:0] sr_q,       sr_d;
    logic [7:0] adb_q,      adb_d;
    logic       stb_q,      stb_d;
    logic       irq_q,      irq_d;
    logic       ovr_q,      ovr_d;

    logic w_last;
    logic w_take;
    logic w_set_irq;
    logic w_set_ovr;
    logic w_done_in;

    assign w_last = (bit_cnt_q == c_BIT_LAST) && (tick_q == c_TICK_LAST);

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_cnt_d  = bit_cnt_q;
        hold_d     = hold_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        sr_d       = sr_q;
        adb_d      = adb_q;
        stb_d      = 1'b0;
        w_take     = 1'b0;
        w_set_irq  = 1'b0;
        w_set_ovr  = 1'b0;
        w_done_in  = 1'b0;

        if (sr_wr) begin
            sr_d = cpu_din;
        end

        case (state_q)
            S_IDLE: begin
                if (sr_wr && sr_dir) begin
                    state_d   = S_SHOUT;
                    tick_d    = 8'd0;
                    bit_cnt_d = 3'd0;
                end else if (!sr_dir && (pend_vld_q || adb_dout_strobe)) begin
                    state_d   = S_SHIN;
                    tick_d    = 8'd0;
                    bit_cnt_d = 3'd0;
                    // Older buffered byte goes first; a same-cycle arrival refills the buffer below.
                    if (pend_vld_q) begin
                        hold_d     = pend_q;
                        pend_vld_d = 1'b0;
                    end else begin
                        hold_d = adb_dout;
                        w_take = 1'b1;
                    end
                end
            end
            S_SHOUT: begin
                if (!sr_dir) begin
                    state_d = S_IDLE;
                end else if (sr_wr) begin
                    tick_d    = 8'd0;
                    bit_cnt_d = 3'd0;
                end else if (w_last) begin
                    state_d   = S_IDLE;
                    adb_d     = sr_q;
                    stb_d     = 1'b1;
                    w_set_irq = 1'b1;
                end else if (tick_q == c_TICK_LAST) begin
                    tick_d    = 8'd0;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end else begin
                    tick_d = tick_q + 8'd1;
                end
            end
            S_SHIN: begin
                if (sr_dir) begin
                    state_d = S_IDLE;
                end else if (w_last) begin
                    state_d   = S_IDLE;
                    w_done_in = 1'b1;
                    w_set_irq = 1'b1;
                end else if (tick_q == c_TICK_LAST) begin
                    tick_d    = 8'd0;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end else begin
                    tick_d = tick_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A completing shift-in owns SR over a coincident CPU write.
        if (w_done_in) begin
            sr_d = hold_q;
        end

        if (adb_dout_strobe && !w_take) begin
            if (!pend_vld_d) begin
                pend_d     = adb_dout;
                pend_vld_d = 1'b1;
            end else begin
                w_set_ovr = 1'b1;
            end
        end

        if (w_set_irq) begin
            irq_d = 1'b1;
        end else if (sr_rd || sr_wr) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end

        if (w_set_ovr) begin
            ovr_d = 1'b1;
        end else if (sr_rd) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q    <= S_IDLE;
            tick_q     <= 8'd0;
            bit_cnt_q  <= 3'd0;
            hold_q     <= 8'h00;
            pend_q     <= 8'h00;
            pend_vld_q <= 1'b0;
            sr_q       <= 8'h00;
            adb_q      <= 8'h00;
            stb_q      <= 1'b0;
            irq_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else if (clk_en) begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_cnt_q  <= bit_cnt_d;
            hold_q     <= hold_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            sr_q       <= sr_d;
            adb_q      <= adb_d;
            stb_q      <= stb_d;
            irq_q      <= irq_d;
            ovr_q      <= ovr_d;
        end
    end

    assign sr_dout        = sr_q;
    assign sr_irq         = irq_q;
    assign viaBusy        = (state_q != S_IDLE);
    assign adb_din        = adb_q;
    assign adb_din_strobe = stb_q;
    assign overrun        = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_via_adb_shifter.sv
// ============================================================================
// Module   : tb_via_adb_shifter
// Function : Self-checking bench for via_adb_shifter (BIT_TICKS = 2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_via_adb_shifter;

    localparam int BT   = 2;
    localparam int BYTE = 8 * BT;

    logic       clk = 1'b0;
    logic       _reset;
    logic       clk_en;
    logic       sr_dir;
    logic       sr_wr;
    logic       sr_rd;
    logic [7:0] cpu_din;
    logic [7:0] sr_dout;
    logic       sr_irq;
    logic       viaBusy;
    logic [7:0] adb_din;
    logic       adb_din_strobe;
    logic [7:0] adb_dout;
    logic       adb_dout_strobe;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    // Behavioural model: one countdown of remaining ticks per byte and a queue for the buffer.
    int         m_mode;   // 0 idle, 1 shifting out, 2 shifting in
    int         m_left;
    logic [7:0] m_hold;
    logic [7:0] m_pend[$];
    logic [7:0] m_sr;
    logic [7:0] m_adb;
    logic       m_stb;
    logic       m_irq;
    logic       m_ovr;

    via_adb_shifter #(.BIT_TICKS(BT)) dut (
        .clk             (clk),
        ._reset          (_reset),
        .clk_en          (clk_en),
        .sr_dir          (sr_dir),
        .sr_wr           (sr_wr),
        .sr_rd           (sr_rd),
        .cpu_din         (cpu_din),
        .sr_dout         (sr_dout),
        .sr_irq          (sr_irq),
        .viaBusy         (viaBusy),
        .adb_din         (adb_din),
        .adb_din_strobe  (adb_din_strobe),
        .adb_dout        (adb_dout),
        .adb_dout_strobe (adb_dout_strobe),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = 0;
        m_left = 0;
        m_hold = 8'h00;
        m_pend.delete();
        m_sr   = 8'h00;
        m_adb  = 8'h00;
        m_stb  = 1'b0;
        m_irq  = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic model_step();
        logic set_irq, set_ovr, consumed, done_in;
        set_irq  = 1'b0;
        set_ovr  = 1'b0;
        consumed = 1'b0;
        done_in  = 1'b0;
        if (clk_en) begin
            m_stb = 1'b0;
            if (m_mode == 1) begin
                if (!sr_dir) m_mode = 0;
                else if (sr_wr) m_left = BYTE;
                else begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_adb = m_sr; m_stb = 1'b1; set_irq = 1'b1; m_mode = 0;
                    end
                end
            end else if (m_mode == 2) begin
                if (sr_dir) m_mode = 0;
                else begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        done_in = 1'b1; set_irq = 1'b1; m_mode = 0;
                    end
                end
            end else begin
                if (sr_wr && sr_dir) begin
                    m_mode = 1; m_left = BYTE;
                end else if (!sr_dir && (m_pend.size() > 0 || adb_dout_strobe)) begin
                    m_mode = 2; m_left = BYTE;
                    if (m_pend.size() > 0) m_hold = m_pend.pop_front();
                    else begin m_hold = adb_dout; consumed = 1'b1; end
                end
            end
            if (done_in) m_sr = m_hold;
            else if (sr_wr) m_sr = cpu_din;
            if (adb_dout_strobe && !consumed) begin
                if (m_pend.size() == 0) m_pend.push_back(adb_dout);
                else set_ovr = 1'b1;
            end
            if (set_irq) m_irq = 1'b1;
            else if (sr_rd || sr_wr) m_irq = 1'b0;
            if (set_ovr) m_ovr = 1'b1;
            else if (sr_rd) m_ovr = 1'b0;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sr_wr = 1'b0; sr_rd = 1'b0; adb_dout_strobe = 1'b0;
    endtask

    task automatic test_reset();
        _reset = 1'b0; clk_en = 1'b1; sr_dir = 1'b1; cpu_din = 8'h00; adb_dout = 8'h00;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        _reset = 1'b1;
        checks++; if (sr_dout !== 8'h00) begin errors++; $display("FAIL reset_sr_dout got %h want 00", sr_dout); end
        checks++; if (adb_din !== 8'h00) begin errors++; $display("FAIL reset_adb_din got %h want 00", adb_din); end
        checks++; if ({sr_irq, viaBusy, adb_din_strobe, overrun} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {sr_irq, viaBusy, adb_din_strobe, overrun});
        end
    endtask

    task automatic test_shift_out();
        int n_busy, n_stb, stb_at;
        n_busy = 0; n_stb = 0; stb_at = -1;
        sr_dir = 1'b1; sr_wr = 1'b1; cpu_din = 8'h3C;
        cycle();
        sr_wr = 1'b0;
        checks++; if (sr_dout !== 8'h3C) begin errors++; $display("FAIL shout_load got %h want 3c", sr_dout); end
        for (int i = 0; i <= 20; i++) begin
            if (viaBusy) n_busy++;
            if (adb_din_strobe) begin n_stb++; stb_at = i; end
            if (i < 20) cycle();
        end
        checks++; if (n_busy != BYTE) begin errors++; $display("FAIL shout_busy_len got %0d want %0d", n_busy, BYTE); end
        checks++; if (n_stb != 1 || stb_at != BYTE) begin
            errors++; $display("FAIL shout_strobe got count %0d at %0d want 1 at %0d", n_stb, stb_at, BYTE);
        end
        checks++; if (adb_din !== 8'h3C) begin errors++; $display("FAIL shout_adb_din got %h want 3c", adb_din); end
        checks++; if (sr_irq !== 1'b1) begin errors++; $display("FAIL shout_irq got %b want 1", sr_irq); end
    endtask

    task automatic test_shift_in();
        sr_dir = 1'b0; adb_dout = 8'hA5; adb_dout_strobe = 1'b1;
        cycle();
        adb_dout_strobe = 1'b0;
        repeat (BYTE - 1) cycle();
        checks++; if (sr_dout !== 8'h3C) begin errors++; $display("FAIL shin_early got %h want 3c", sr_dout); end
        cycle();
        checks++; if (sr_dout !== 8'hA5) begin errors++; $display("FAIL shin_data got %h want a5", sr_dout); end
        checks++; if (sr_irq !== 1'b1) begin errors++; $display("FAIL shin_irq got %b want 1", sr_irq); end
        sr_rd = 1'b1;
        cycle();
        sr_rd = 1'b0;
        checks++; if (sr_irq !== 1'b0) begin errors++; $display("FAIL shin_rd_clear got %b want 0", sr_irq); end
    endtask

    task automatic test_pending_overrun();
        logic seen11, seen22;
        seen11 = 1'b0; seen22 = 1'b0;
        sr_dir = 1'b0; adb_dout_strobe = 1'b1;
        adb_dout = 8'h11; cycle();
        adb_dout = 8'h22; cycle();
        adb_dout = 8'h33; cycle();
        adb_dout_strobe = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", overrun); end
        for (int i = 0; i < 80 && !seen22; i++) begin
            cycle();
            if (sr_dout === 8'h11) seen11 = 1'b1;
            if (sr_dout === 8'h22 && seen11) seen22 = 1'b1;
        end
        checks++; if (!(seen11 && seen22)) begin
            errors++; $display("FAIL ovr_order got seen11=%b seen22=%b want 1 1", seen11, seen22);
        end
        repeat (30) cycle();
        checks++; if (sr_dout !== 8'h22 || viaBusy !== 1'b0) begin
            errors++; $display("FAIL ovr_drop got sr=%h busy=%b want 22 0", sr_dout, viaBusy);
        end
        sr_rd = 1'b1;
        cycle();
        sr_rd = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", overrun); end
    endtask

    task automatic test_abort();
        int n_stb;
        n_stb = 0;
        sr_dir = 1'b1; sr_wr = 1'b1; cpu_din = 8'h55;
        cycle();
        sr_wr = 1'b0;
        repeat (5) cycle();
        sr_dir = 1'b0;
        cycle();
        checks++; if (viaBusy !== 1'b0 || sr_irq !== 1'b0) begin
            errors++; $display("FAIL abort_state got busy=%b irq=%b want 0 0", viaBusy, sr_irq);
        end
        for (int i = 0; i < 20; i++) begin
            if (adb_din_strobe) n_stb++;
            cycle();
        end
        checks++; if (n_stb != 0) begin errors++; $display("FAIL abort_strobe got %0d want 0", n_stb); end
    endtask

    task automatic test_reset_mid();
        int n_stb;
        n_stb = 0;
        sr_dir = 1'b1; sr_wr = 1'b1; cpu_din = 8'hAA;
        cycle();
        sr_wr = 1'b0;
        repeat (6) cycle();
        #2;
        _reset = 1'b0;
        model_reset();
        #1;
        checks++; if ({sr_dout, adb_din, sr_irq, viaBusy, adb_din_strobe, overrun} !== 20'h0) begin
            errors++; $display("FAIL rstmid_outputs got sr=%h adb=%h flags=%b want 00 00 0000",
                               sr_dout, adb_din, {sr_irq, viaBusy, adb_din_strobe, overrun});
        end
        repeat (2) @(posedge clk);
        #1;
        _reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (adb_din_strobe) n_stb++;
            cycle();
        end
        checks++; if (n_stb != 0 || viaBusy !== 1'b0) begin
            errors++; $display("FAIL rstmid_after got strobes=%0d busy=%b want 0 0", n_stb, viaBusy);
        end
    endtask

    task automatic test_set_wins();
        sr_dir = 1'b0; adb_dout = 8'h5A; adb_dout_strobe = 1'b1;
        cycle();
        adb_dout_strobe = 1'b0;
        repeat (BYTE - 1) cycle();
        sr_rd = 1'b1;
        cycle();
        sr_rd = 1'b0;
        checks++; if (sr_irq !== 1'b1 || sr_dout !== 8'h5A) begin
            errors++; $display("FAIL set_wins got irq=%b sr=%h want 1 5a", sr_irq, sr_dout);
        end
        sr_rd = 1'b1;
        cycle();
        sr_rd = 1'b0;
        checks++; if (sr_irq !== 1'b0) begin errors++; $display("FAIL set_wins_clear got %b want 0", sr_irq); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            clk_en          = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) sr_dir = ~sr_dir;
            sr_wr           = ($urandom_range(0, 39) == 0);
            sr_rd           = ($urandom_range(0, 29) == 0);
            adb_dout_strobe = ($urandom_range(0, 24) == 0);
            cpu_din         = 8'($urandom);
            adb_dout        = 8'($urandom);
            cycle();
            checks++;
            if (sr_dout !== m_sr || sr_irq !== m_irq || viaBusy !== (m_mode != 0) ||
                adb_din !== m_adb || adb_din_strobe !== m_stb || overrun !== m_ovr) begin
                errors++;
                $display("FAIL random_cycle%0d got sr=%h irq=%b busy=%b adb=%h stb=%b ovr=%b want %h %b %b %h %b %b",
                         i, sr_dout, sr_irq, viaBusy, adb_din, adb_din_strobe, overrun,
                         m_sr, m_irq, (m_mode != 0), m_adb, m_stb, m_ovr);
            end
        end
        clk_en = 1'b1;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_shift_out();
        test_shift_in();
        test_pending_overrun();
        test_abort();
        test_reset_mid();
        test_set_wins();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
